multi_clken_gen: RTL and testbench

- Parametrised, fully digital successor to the fixed single-output 25 MHz clock generator.
- Produces NUM_CH independent clock-enable pulses plus matching square-wave strobes from the one reference clock.
- Each channel has a run-time divide ratio and phase offset, a per-channel lock indication and an aggregate lock output.
- Sits at the top level and feeds the VGA/pipe/game-tick logic, replacing extra clock domains with enables.

---
 rtl/multi_clken_gen_pkg.sv | 19 +
 rtl/multi_clken_ch.sv | 89 ++++++++
 rtl/multi_clken_gen.sv | 79 +++++++
 tb/tb_multi_clken_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_clken_gen_pkg.sv
// Shared types and constants for the multi-channel clock-enable generator.
package multi_clken_gen_pkg;

    localparam int CH_IDX_W  = 4;
    localparam int CNT_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } ch_state_t;

    // Request fields held at the widest supported CNT_W; channels take the low CNT_W bits.
    typedef struct packed {
        logic [CNT_W_MAX-1:0] div;
        logic [CNT_W_MAX-1:0] phase;
    } ch_cfg_t;

endpackage

// File: rtl/multi_clken_ch.sv
// One enable channel: divide counter, lock-period counter, state machine, output decode.
// MULTI_CLKEN_GEN_ALIGN_EN adds the align input and per-channel phase storage.
//
//  state  | meaning
//  IDLE   | div=0, counter parked at 0, all outputs low
//  SETTLE | counting, waiting for LOCK_PERIODS complete periods
//  RUN    | counting, locked
module multi_clken_ch
    import multi_clken_gen_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int DEFAULT_DIV   = 2,
    parameter int LOCK_PERIODS  = 4,
    parameter int GATE_UNLOCKED = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
    input  logic             align,
`endif
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_div,
    input  logic [CNT_W-1:0] ld_phase,
    output logic             clken,
    output logic             sq,
    output logic             ch_locked,
    output logic             active
);

    localparam int PER_W = $clog2(LOCK_PERIODS + 1);

    ch_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [PER_W-1:0] periods;
    logic             wrap;
    logic             en;

`ifdef MULTI_CLKEN_GEN_ALIGN_EN
    logic [CNT_W-1:0] phase_q;
`endif

    assign wrap = (cnt == div - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SETTLE;
            cnt     <= '0;
            div     <= CNT_W'(DEFAULT_DIV);
            periods <= '0;
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
            phase_q <= '0;
`endif
        end else if (ld) begin
            div     <= ld_div;
            cnt     <= (ld_div == '0) ? '0 : ld_phase;
            periods <= '0;
            state   <= (ld_div == '0) ? IDLE : SETTLE;
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
            phase_q <= ld_phase;
`endif
        end
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
        // Realignment replaces the count step; state and period count are kept.
        else if (align && state != IDLE) begin
            cnt <= phase_q;
        end
`endif
        else if (state != IDLE) begin
            if (wrap) begin
                cnt <= '0;
                if (state == SETTLE) begin
                    periods <= periods + PER_W'(1);
                    if (periods == PER_W'(LOCK_PERIODS - 1))
                        state <= RUN;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign en        = (state == RUN) || (state == SETTLE && GATE_UNLOCKED == 0);
    assign clken     = en && wrap;
    assign sq        = en && (cnt < (div >> 1));
    assign ch_locked = (state == RUN);
    assign active    = (state != IDLE);

endmodule

// File: rtl/multi_clken_gen.sv
// Multi-channel clock-enable generator: config handshake, validation and lock aggregation.
// Optional MULTI_CLKEN_GEN_ALIGN_EN adds an align input that reloads every running channel's phase.
module multi_clken_gen
    import multi_clken_gen_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 16,
    parameter int DEFAULT_DIV   = 2,
    parameter int LOCK_PERIODS  = 4,
    parameter int GATE_UNLOCKED = 1
) (
    input  logic                refclk,
    input  logic                rst,
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
    input  logic                align,
`endif
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_phase,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   clken,
    output logic [NUM_CH-1:0]   sq,
    output logic [NUM_CH-1:0]   ch_locked,
    output logic                locked
);

    ch_cfg_t           req;
    logic              xfer;
    logic              bad;
    logic [NUM_CH-1:0] ld;
    logic [NUM_CH-1:0] active;

    assign req.div   = CNT_W_MAX'(cfg_div);
    assign req.phase = CNT_W_MAX'(cfg_phase);

    assign xfer = cfg_valid && cfg_ready;
    assign bad  = (int'(cfg_ch) >= NUM_CH) ||
                  ((req.div != '0) && (req.phase >= req.div));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ld[i] = xfer && !bad && (cfg_ch == CH_IDX_W'(i));

        multi_clken_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .LOCK_PERIODS (LOCK_PERIODS),
            .GATE_UNLOCKED(GATE_UNLOCKED)
        ) u_ch (
            .clk      (refclk),
            .rst      (rst),
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
            .align    (align),
`endif
            .ld       (ld[i]),
            .ld_div   (cfg_div),
            .ld_phase (cfg_phase),
            .clken    (clken[i]),
            .sq       (sq[i]),
            .ch_locked(ch_locked[i]),
            .active   (active[i])
        );
    end

    // Every RUN channel is active, so equality means all active channels are locked.
    always_ff @(posedge refclk) begin
        if (rst) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            cfg_ready <= !xfer;
            cfg_err   <= xfer && bad;
            locked    <= (|active) && (ch_locked == active);
        end
    end

endmodule

// File: tb/tb_multi_clken_gen.sv
// Bench for multi_clken_gen: directed literal checks plus randomized traffic against a behavioural model.
module tb_multi_clken_gen;

    localparam int NUM_CH        = 4;
    localparam int CNT_W         = 16;
    localparam int DEFAULT_DIV   = 2;
    localparam int LOCK_PERIODS  = 4;
    localparam int GATE_UNLOCKED = 1;

    logic              refclk    = 1'b0;
    logic              rst       = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [3:0]        cfg_ch    = '0;
    logic [CNT_W-1:0]  cfg_div   = '0;
    logic [CNT_W-1:0]  cfg_phase = '0;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NUM_CH-1:0] clken;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] ch_locked;
    logic              locked;
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
    logic              align = 1'b0;
`endif

    multi_clken_gen #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .LOCK_PERIODS (LOCK_PERIODS),
        .GATE_UNLOCKED(GATE_UNLOCKED)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
        .align    (align),
`endif
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_err  (cfg_err),
        .clken    (clken),
        .sq       (sq),
        .ch_locked(ch_locked),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: st 0=idle, 1=settling, 2=locked.
    int m_div[NUM_CH];
    int m_cnt[NUM_CH];
    int m_per[NUM_CH];
    int m_ph[NUM_CH];
    int m_st[NUM_CH];
    bit m_ready, m_err, m_locked;
    bit m_live = 1'b0;

    always @(posedge refclk) begin
        int  n_act, n_run;
        bit  xfer, bad, do_align;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = DEFAULT_DIV; m_cnt[i] = 0; m_per[i] = 0; m_ph[i] = 0; m_st[i] = 1;
            end
            m_ready = 0; m_err = 0; m_locked = 0; m_live = 1;
        end else begin
            n_act = 0; n_run = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_st[i] != 0) n_act++;
                if (m_st[i] == 2) n_run++;
            end
            xfer = cfg_valid && m_ready;
            bad  = (int'(cfg_ch) >= NUM_CH) || (cfg_div != 0 && cfg_phase >= cfg_div);
            do_align = 0;
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
            do_align = align;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_st[i] != 0) begin
                    if (do_align) m_cnt[i] = m_ph[i];
                    else if (m_cnt[i] == m_div[i] - 1) begin
                        m_cnt[i] = 0;
                        if (m_st[i] == 1) begin
                            m_per[i]++;
                            if (m_per[i] == LOCK_PERIODS) m_st[i] = 2;
                        end
                    end else m_cnt[i]++;
                end
            end
            if (xfer && !bad) begin
                m_div[cfg_ch] = int'(cfg_div);
                m_cnt[cfg_ch] = (cfg_div == 0) ? 0 : int'(cfg_phase);
                m_per[cfg_ch] = 0;
                m_st[cfg_ch]  = (cfg_div == 0) ? 0 : 1;
                m_ph[cfg_ch]  = int'(cfg_phase);
            end
            m_err    = xfer && bad;
            m_ready  = !xfer;
            m_locked = (n_act > 0) && (n_act == n_run);
        end
    end

    always @(negedge refclk) begin
        logic [NUM_CH-1:0] e_clk, e_sq, e_lk;
        bit en;
        if (m_live) begin
            for (int i = 0; i < NUM_CH; i++) begin
                en       = (m_st[i] == 2) || (m_st[i] == 1 && GATE_UNLOCKED == 0);
                e_clk[i] = en && (m_cnt[i] == m_div[i] - 1);
                e_sq[i]  = en && (m_cnt[i] < m_div[i] / 2);
                e_lk[i]  = (m_st[i] == 2);
            end
            check("clken", 32'(clken), 32'(e_clk));
            check("sq", 32'(sq), 32'(e_sq));
            check("ch_locked", 32'(ch_locked), 32'(e_lk));
            check("locked", 32'(locked), 32'(m_locked));
            check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
            check("cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic send(input int ch, input int div, input int ph);
        cfg_valid = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_div   = CNT_W'(div);
        cfg_phase = CNT_W'(ph);
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_outs", {clken, sq, ch_locked}, 32'h0);
        check("rst_flags", {29'h0, locked, cfg_err, cfg_ready}, 32'h0);
        rst = 1'b0;

        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) check("ready_after_rst", 32'(cfg_ready), 32'h1);
            if (k == 7) check("settle_gated", {clken, ch_locked}, 32'h0);
            if (k == 8) check("lock_at_8", {ch_locked, 3'b000, locked}, 32'hF0);
            if (k == 9) check("agg_lock_at_9", {locked, clken, sq}, 32'h1F0);
            if (k == 10) check("sq_phase", {clken, sq}, 32'h0F);
        end

        send(1, 5, 3);
        check("cfg_apply", {cfg_ready, cfg_err, locked, ch_locked, clken}, 32'h0DD | (32'h1 << 8));
        tick();
        check("ready_back", {cfg_ready, locked}, 32'h2);

        send(2, 7, 7);
        check("bad_phase", {cfg_err, cfg_ready, ch_locked}, 32'h2D);
        tick();
        check("err_pulse_end", {cfg_err, cfg_ready}, 32'h1);
        send(9, 3, 0);
        check("bad_ch", {cfg_err, cfg_ready}, 32'h2);
        tick();

        for (int i = 0; i < NUM_CH; i++) begin
            send(i, 0, 0);
            tick();
        end
        tick();
        check("all_idle", {locked, ch_locked, clken, sq}, 32'h0);

        send(3, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) check("div1_lock", {ch_locked, clken, sq, 3'b000, locked}, 32'h8800);
            if (k == 5) check("div1_run", {ch_locked, clken, sq, 3'b000, locked}, 32'h8801);
        end

        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 16'd3; cfg_phase = 16'd1; rst = 1'b1;
        tick();
        check("rst_abort", {clken, sq, ch_locked, cfg_ready, cfg_err, locked}, 32'h0);
        rst = 1'b0; cfg_valid = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        check("defaults_back", 32'(ch_locked), 32'hF);

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 399) == 0);
            cfg_valid = ($urandom_range(0, 11) == 0);
            cfg_ch    = 4'($urandom_range(0, 5));
            cfg_div   = CNT_W'($urandom_range(0, 9));
            cfg_phase = CNT_W'($urandom_range(0, 9));
`ifdef MULTI_CLKEN_GEN_ALIGN_EN
            align     = ($urandom_range(0, 29) == 0);
`endif
            tick();
        end
        rst = 1'b0; cfg_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
